qsys_led_key_servicer: RTL
==========================

# qsys_led_key_servicer

Hardware interrupt servicer for the 4-bit key PIO with edge capture in the Qsys LED design. It acts as the PIO's only Avalon-MM master. After reset it programs the IRQ mask. On each `irq` it reads the edge-capture register, pushes the captured key bits into a small event FIFO, and clears exactly the bits it read. The downstream LED logic consumes key events through a valid/ready stream instead of a soft CPU ISR.

## Interface
- `IRQ_MASK_INIT`, 4'hF: mask written to PIO address 2 after reset.
- `FIFO_DEPTH`, 4: event FIFO entries; power of two, at least 2.
- `clk` in 1: single clock shared with the PIO.
- `reset_n` in 1: asynchronous, active-low reset.
- `irq` in 1: PIO interrupt, i.e. OR of edge_capture & irq_mask.
- `avm_address` out 2: PIO register address.
- `avm_chipselect` out 1: PIO select.
- `avm_write_n` out 1: active-low write.
- `avm_writedata` out 32: PIO write data; bits 31:4 always 0.
- `avm_readdata` in 32: PIO registered read data; only bits 3:0 are used.
- `cfg_mask` in 4: new IRQ mask.
- `cfg_mask_wr` in 1: one-cycle request to write `cfg_mask`.
- `evt_valid` out 1: FIFO not empty.
- `evt_data` out 4: head event; one bit per key edge (show-ahead).
- `evt_ready` in 1: pop when high together with `evt_valid`.
- `evt_level` out log2(FIFO_DEPTH)+1: FIFO occupancy.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- PIO register map: 0 = data, 2 = irq_mask, 3 = edge_capture. Writing a 1 to an edge_capture bit clears that bit.
- PIO writes take effect at the clock edge where `avm_chipselect`=1 and `avm_write_n`=0. The PIO has no waitrequest.
- PIO reads return data one cycle after the address is presented. `avm_readdata` is sampled in the cycle after the read cycle.
- Idle bus values: `avm_chipselect`=0, `avm_write_n`=1, `avm_address`=0, `avm_writedata`=0.
- FSM states and transitions:
  - INIT: write `IRQ_MASK_INIT` to address 2. Load it into the internal `mask_q`. Go to IDLE.
  - IDLE: if a mask request is pending, go to MASK. Otherwise, if `irq`=1 and the FIFO is not full, go to RD. Otherwise stay in IDLE.
  - MASK: write the pending value to address 2. Update `mask_q`. Clear the pending flag. Go to IDLE.
  - RD: chipselect=1, write_n=1, address=3. Go to CAP.
  - CAP: compute `cap = avm_readdata[3:0] & mask_q`. If `cap`=0 (spurious interrupt), go to IDLE with no push. Otherwise push `cap` into the FIFO and go to CLR.
  - CLR: write `cap` to address 3. Go to IDLE.
- `cfg_mask_wr` latches `cfg_mask` into a pending register. A later request overwrites a still-pending one (last value wins).
- Mask requests have priority over interrupt service in IDLE. A request never interrupts an in-flight RD/CAP/CLR sequence.
- Only bits captured in CAP are cleared. A new edge on another key arriving during RD/CAP stays captured and re-raises `irq`.
- FIFO full gate: when the FIFO is full, service is not started and `irq` stays pending. Edges stay sticky in the PIO, so no event is lost.
- Because fullness is checked in IDLE, the FIFO always has room at the push in CAP. There is no overflow path.
- Simultaneous push and pop in the FIFO: both happen and the level is unchanged. A pop on an empty FIFO is ignored.
- Reset mid-sequence: everything returns to INIT. The FIFO empties and any pending mask request is dropped. Uncleared PIO edges re-raise `irq` after INIT.

## Timing
- Reset values:
  - FSM state = INIT, `mask_q` = 0, FIFO empty.
  - `evt_valid`=0, `evt_data`=0, `evt_level`=0.
  - Avalon outputs at idle values.
  - `busy`=1, since INIT is not IDLE.
- INIT occupies the first cycle after reset deasserts. IDLE is reached the next cycle.
- Bus outputs are decoded from the state register, with no combinational path from inputs.
  - Exception: `avm_writedata`, which comes from the `cap` register or the pending-mask register.
- Service latency, with `irq` high in IDLE at cycle t:
  - RD at t+1, CAP at t+2, CLR at t+3.
  - `evt_valid` rises at t+3.
  - PIO bit cleared at the t+3/t+4 edge. IDLE at t+4.
- A new service of still-high `irq` can start at t+4, giving a minimum of 4 cycles per event.
- Mask request: `cfg_mask_wr` at cycle c, with the FSM in IDLE:
  - MASK at c+1.
  - The PIO mask is updated at the c+1/c+2 edge.
- Known PIO limitation: an edge on a bit coincident with its clear in CLR is lost, because the PIO clear wins.

## Structure
- Shared package `qsys_led_key_pkg` holds:
  - the FSM state encoding (INIT, IDLE, MASK, RD, CAP, CLR);
  - the PIO address constants (`KEY_ADDR_DATA`=0, `KEY_ADDR_MASK`=2, `KEY_ADDR_EDGE`=3);
  - the key width constant (4).
- One sub-module, `key_evt_fifo`: synchronous show-ahead FIFO with width 4 and depth `FIFO_DEPTH`. It provides push, pop, full, empty and level.

## Test plan
- Reset release with default parameters → one write of 4'hF to address 2 at the first post-reset cycle; `busy` goes low one cycle later.
- Edge on key 1 (PIO model, `irq`=1) → RD at address 3, `evt_data`=4'h2 with `evt_valid` at t+3, clear write data 0x2 at t+3, `irq` low at t+4.
- Key 0 edge followed by a key 2 edge during CAP → first event 4'h1 and clear 0x1; `irq` stays high; second service yields 4'h4.
- `evt_ready`=0 with 4 events queued → `evt_level`=4, no further RD while `irq` is high. One pop → service resumes and the 5th event arrives within 5 cycles.
- `cfg_mask`=4'h3 with `cfg_mask_wr` during a CAP → write 0x3 to address 2 after CLR; a later key 3 edge gives no service and `busy` stays 0.
- Spurious interrupt (`irq`=1, readdata=0) → RD, CAP, then IDLE with no push and no clear write. Separately, `reset_n` low during CLR → FIFO empty and a mask rewrite on release.

Source files
------------

// File: rtl/qsys_led_key_pkg.sv
// Shared definitions for the key PIO interrupt servicer: servicer FSM
// encoding, PIO register addresses and the key width.
package qsys_led_key_pkg;

    localparam int KEY_W = 4;

    localparam logic [1:0] KEY_ADDR_DATA = 2'd0;
    localparam logic [1:0] KEY_ADDR_MASK = 2'd2;
    localparam logic [1:0] KEY_ADDR_EDGE = 2'd3;

    typedef enum logic [2:0] {
        ST_INIT = 3'd0,
        ST_IDLE = 3'd1,
        ST_MASK = 3'd2,
        ST_RD   = 3'd3,
        ST_CAP  = 3'd4,
        ST_CLR  = 3'd5
    } svc_state_t;

endpackage

// File: rtl/key_evt_fifo.sv
// Show-ahead event FIFO for captured key bits. The head entry is visible on
// head_o whenever the FIFO is not empty and reads as zero when it is empty.
// A push while full and a pop while empty are both ignored.
module key_evt_fifo
    import qsys_led_key_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [KEY_W-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [KEY_W-1:0]         head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [KEY_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign level_o = level_q;
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // Storage write; contents need no reset because the level gates the head.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/qsys_led_key_servicer.sv
// Avalon-MM master that services the key PIO edge-capture interrupt.
// After reset it programs the PIO IRQ mask; on each interrupt it reads the
// edge-capture register, queues the enabled captured bits as one event and
// clears exactly those bits. Events leave through a valid/ready stream.
//
// Event stream handshake: evt_valid is high while an event is queued and
// evt_data holds it; the event is consumed at a rising clock edge where both
// evt_valid and evt_ready are high. evt_data stays stable until consumed.
module qsys_led_key_servicer
    import qsys_led_key_pkg::*;
#(
    parameter logic [3:0] IRQ_MASK_INIT = 4'hF,
    parameter int         FIFO_DEPTH    = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        irq,
    output logic [1:0]                  avm_address,
    output logic                        avm_chipselect,
    output logic                        avm_write_n,
    output logic [31:0]                 avm_writedata,
    input  logic [31:0]                 avm_readdata,
    input  logic [3:0]                  cfg_mask,
    input  logic                        cfg_mask_wr,
    output logic                        evt_valid,
    output logic [3:0]                  evt_data,
    input  logic                        evt_ready,
    output logic [$clog2(FIFO_DEPTH):0] evt_level,
    output logic                        busy,
    output svc_state_t                  dbg_state
);

    svc_state_t       state_q;
    logic [KEY_W-1:0] mask_q;
    logic             pend_valid_q;
    logic [KEY_W-1:0] pend_mask_q;
    logic [KEY_W-1:0] cap_q;
    logic [KEY_W-1:0] cap_d;
    logic [KEY_W-1:0] wr_data;
    logic             fifo_push;
    logic             fifo_full;
    logic             fifo_empty;
    logic             unused_rd_hi;

    // Only the key bits of the PIO read data carry information.
    assign unused_rd_hi = ^avm_readdata[31:KEY_W];

    // Read data is valid in CAP, one cycle after the address went out in RD.
    assign cap_d     = avm_readdata[KEY_W-1:0] & mask_q;
    assign fifo_push = (state_q == ST_CAP) && (cap_d != '0);

    assign busy      = (state_q != ST_IDLE);
    assign dbg_state = state_q;
    assign evt_valid = !fifo_empty;

    // Servicer FSM plus the mask-request holding register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_INIT;
            mask_q       <= '0;
            pend_valid_q <= 1'b0;
            pend_mask_q  <= '0;
            cap_q        <= '0;
        end else begin
            if (cfg_mask_wr) begin
                pend_valid_q <= 1'b1;
                pend_mask_q  <= cfg_mask;
            end
            case (state_q)
                ST_INIT: begin
                    mask_q  <= IRQ_MASK_INIT;
                    state_q <= ST_IDLE;
                end
                ST_IDLE: begin
                    // Mask requests win; a same-cycle request goes straight to MASK.
                    if (pend_valid_q || cfg_mask_wr) begin
                        state_q <= ST_MASK;
                    end else if (irq && !fifo_full) begin
                        state_q <= ST_RD;
                    end
                end
                ST_MASK: begin
                    mask_q <= pend_mask_q;
                    // A request arriving now stays pending for another MASK pass.
                    if (!cfg_mask_wr) begin
                        pend_valid_q <= 1'b0;
                    end
                    state_q <= ST_IDLE;
                end
                ST_RD: begin
                    state_q <= ST_CAP;
                end
                ST_CAP: begin
                    cap_q   <= cap_d;
                    // Nothing enabled was captured: spurious, skip push and clear.
                    state_q <= (cap_d != '0) ? ST_CLR : ST_IDLE;
                end
                ST_CLR: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_INIT;
                end
            endcase
        end
    end

    // Bus decode from the state register; held idle while reset is asserted.
    always_comb begin
        avm_chipselect = 1'b0;
        avm_write_n    = 1'b1;
        avm_address    = KEY_ADDR_DATA;
        wr_data        = '0;
        if (reset_n) begin
            case (state_q)
                ST_INIT: begin
                    avm_chipselect = 1'b1;
                    avm_write_n    = 1'b0;
                    avm_address    = KEY_ADDR_MASK;
                    wr_data        = IRQ_MASK_INIT;
                end
                ST_MASK: begin
                    avm_chipselect = 1'b1;
                    avm_write_n    = 1'b0;
                    avm_address    = KEY_ADDR_MASK;
                    wr_data        = pend_mask_q;
                end
                ST_RD: begin
                    avm_chipselect = 1'b1;
                    avm_address    = KEY_ADDR_EDGE;
                end
                ST_CLR: begin
                    avm_chipselect = 1'b1;
                    avm_write_n    = 1'b0;
                    avm_address    = KEY_ADDR_EDGE;
                    wr_data        = cap_q;
                end
                default: begin
                end
            endcase
        end
    end

    assign avm_writedata = {{(32-KEY_W){1'b0}}, wr_data};

    key_evt_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk),
        .rst_ni      (reset_n),
        .push_i      (fifo_push),
        .push_data_i (cap_d),
        .pop_i       (evt_ready),
        .head_o      (evt_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .level_o     (evt_level)
    );

endmodule
